npc_unit: RTL and testbench

- Parametrised next-PC generator that owns the architectural PC register.
- Replaces the combinational next-PC mux with a sequential unit that adds:
  - separate beq/bne modes,
  - a return-address stack (RAS) with hit reporting on returns,
  - fetch stall,
  - an exception/redirect override.
- Sits between the controller/ALU zero flag and instruction memory; drives the fetch address and the link value written back on jal.

---
 rtl/npc_pkg.sv | 24 ++
 rtl/npc_ras.sv | 54 +++++
 rtl/npc_unit.sv | 127 ++++++++++++
 tb/tb_npc_unit.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared next-PC definitions: select encodings and default PC constants.
// Imported by the next-PC unit, its return-address stack, the controller and the bench.
package npc_pkg;

    // Next-PC mode encodings (npc_sel)
    localparam logic [2:0] NPC_SEQ = 3'b000;
    localparam logic [2:0] NPC_BEQ = 3'b001;
    localparam logic [2:0] NPC_BNE = 3'b010;
    localparam logic [2:0] NPC_J   = 3'b011;
    localparam logic [2:0] NPC_JAL = 3'b100;
    localparam logic [2:0] NPC_JR  = 3'b101;
    localparam logic [2:0] NPC_RET = 3'b110;
    localparam logic [2:0] NPC_RSV = 3'b111;

    // Default reset and exception-vector addresses
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

    // Clear the byte-offset bits of an address
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/npc_ras.sv
// Circular return-address stack. A push when full overwrites the oldest entry.
// Ports: clk, rst (sync active-low), push, pop, push_data -> top, count, full, empty.
module npc_ras #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            push_data,
    output logic [ADDR_W-1:0]            top,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_inc;
    logic [PTR_W-1:0]  ptr_dec;

    assign ptr_inc = ptr + PTR_W'(1);
    assign ptr_dec = ptr - PTR_W'(1);

    // ptr always names the most recent entry; the slot is stale when empty
    assign top   = mem[ptr];
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr   <= '0;
            count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            // The pointer wraps, so a push when full lands on the oldest entry
            ptr          <= ptr_inc;
            mem[ptr_inc] <= push_data;
            if (!full) begin
                count <= count + 1'b1;
            end
        end else if (pop && !empty) begin
            ptr   <= ptr_dec;
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/npc_unit.sv
// Next-PC generator owning the PC register, with branch/jump modes and a RAS.
// Ports: clk, rst, stall, redirect, npc_sel, zero, imm, reg_val -> pc, pc_plus4, ras_hit, ras_count.
module npc_unit
    import npc_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF,
    parameter int          RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         redirect,
    input  logic [2:0]                   npc_sel,
    input  logic                         zero,
    input  logic [25:0]                  imm,
    input  logic [31:0]                  reg_val,
    output logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            pc_plus4,
    output logic                         ras_hit,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    localparam int WA_W = ADDR_W - 2;

    localparam logic [31:0] RST_AL = word_align(RESET_PC);
    localparam logic [31:0] EXC_AL = word_align(EXC_VEC);
    localparam logic [ADDR_W-1:0] RST_PC_C = RST_AL[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] EXC_PC_C = EXC_AL[ADDR_W-1:0];

    logic [WA_W-1:0]   wa;
    logic [WA_W-1:0]   wa_inc;
    logic [WA_W-1:0]   br_off;
    logic [WA_W-1:0]   br_wa;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] j_tgt;
    logic [ADDR_W-1:0] jr_tgt;
    logic [ADDR_W-1:0] nxt_pc;
    logic              push_req;
    logic              pop_req;
    logic              advance;
    logic              hit_nxt;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_full;
    logic              ras_empty;
    logic              unused_bits;

    // Arithmetic on the word address wraps modulo 2^(ADDR_W-2)
    assign wa       = pc[ADDR_W-1:2];
    assign wa_inc   = wa + WA_W'(1);
    assign pc_plus4 = {wa_inc, 2'b00};

    assign br_off = {{(WA_W-16){imm[15]}}, imm[15:0]};
    assign br_wa  = wa_inc + br_off;
    assign br_tgt = {br_wa, 2'b00};

    assign jr_tgt = {reg_val[ADDR_W-1:2], 2'b00};

    // Jump keeps the region bits of pc+4 above bit 27, if any exist
    if (ADDR_W > 28) begin : g_jhi
        assign j_tgt = {pc_plus4[ADDR_W-1:28], imm, 2'b00};
    end else begin : g_jlo
        assign j_tgt = {imm, 2'b00};
    end

    always_comb begin
        nxt_pc   = pc_plus4;
        push_req = 1'b0;
        pop_req  = 1'b0;
        case (npc_sel)
            NPC_BEQ: if (zero)  nxt_pc = br_tgt;
            NPC_BNE: if (!zero) nxt_pc = br_tgt;
            NPC_J:   nxt_pc = j_tgt;
            NPC_JAL: begin
                nxt_pc   = j_tgt;
                push_req = 1'b1;
            end
            NPC_JR:  nxt_pc = jr_tgt;
            NPC_RET: begin
                nxt_pc  = jr_tgt;
                pop_req = 1'b1;
            end
            default: nxt_pc = pc_plus4;
        endcase
    end

    // Only an un-stalled, un-redirected cycle commits a mode
    assign advance = !redirect && !stall;

    assign hit_nxt = advance && pop_req && !ras_empty &&
                     (ras_top[ADDR_W-1:2] == reg_val[ADDR_W-1:2]);

    npc_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (advance && push_req),
        .pop       (advance && pop_req),
        .push_data (pc_plus4),
        .top       (ras_top),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc      <= RST_PC_C;
            ras_hit <= 1'b0;
        end else if (redirect) begin
            pc      <= EXC_PC_C;
            ras_hit <= 1'b0;
        end else if (stall) begin
            ras_hit <= 1'b0;
        end else begin
            pc      <= nxt_pc;
            ras_hit <= hit_nxt;
        end
    end

    // Byte-offset bits of reg_val / stack entries and the full flag are not needed here
    assign unused_bits = ^{reg_val, ras_top, ras_full};

endmodule

// File: tb/tb_npc_unit.sv
// Directed, table-driven bench for npc_unit (32-bit and 28-bit instances).
// Ports: none.
module tb_npc_unit;
    import npc_pkg::*;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [2:0]  sel;
        logic        zero;
        logic [25:0] imm;
        logic [31:0] reg_val;
        logic [31:0] exp_pc;
        int          exp_cnt;
        logic        exp_hit;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, stall, redirect, zero;
    logic [2:0]  npc_sel;
    logic [25:0] imm;
    logic [31:0] reg_val;
    logic [31:0] pc, pc_plus4;
    logic        ras_hit;
    logic [2:0]  ras_count;

    logic        rst28, stall28, redirect28, zero28;
    logic [2:0]  sel28;
    logic [25:0] imm28;
    logic [31:0] reg28;
    logic [27:0] pc28, pp4_28;
    logic        hit28;
    logic [2:0]  cnt28;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    npc_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .npc_sel(npc_sel), .zero(zero), .imm(imm), .reg_val(reg_val),
        .pc(pc), .pc_plus4(pc_plus4), .ras_hit(ras_hit),
        .ras_count(ras_count)
    );

    npc_unit #(.ADDR_W(28)) dut28 (
        .clk(clk), .rst(rst28), .stall(stall28), .redirect(redirect28),
        .npc_sel(sel28), .zero(zero28), .imm(imm28), .reg_val(reg28),
        .pc(pc28), .pc_plus4(pp4_28), .ras_hit(hit28),
        .ras_count(cnt28)
    );

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t v(input logic r, input logic s, input logic d,
                               input logic [2:0] sl, input logic z,
                               input logic [25:0] im, input logic [31:0] rv,
                               input logic [31:0] ep, input int ec,
                               input logic eh);
        vec_t t;
        t.rst = r; t.stall = s; t.redirect = d; t.sel = sl; t.zero = z;
        t.imm = im; t.reg_val = rv; t.exp_pc = ep; t.exp_cnt = ec;
        t.exp_hit = eh;
        return t;
    endfunction

    initial begin
        // reset with stall and redirect asserted
        vecs.push_back(v(0,1,1,NPC_SEQ,0,0,0,32'h3000,0,0));
        vecs.push_back(v(0,1,1,NPC_SEQ,0,0,0,32'h3000,0,0));
        vecs.push_back(v(1,0,0,NPC_SEQ,0,0,0,32'h3004,0,0));
        vecs.push_back(v(1,0,0,NPC_SEQ,0,0,0,32'h3008,0,0));
        // branches
        vecs.push_back(v(1,0,0,NPC_BEQ,1,26'hFFFF,0,32'h3008,0,0));
        vecs.push_back(v(1,0,0,NPC_BNE,1,26'hFFFF,0,32'h300C,0,0));
        // JAL / RET
        vecs.push_back(v(0,0,0,NPC_SEQ,0,0,0,32'h3000,0,0));
        vecs.push_back(v(1,0,0,NPC_SEQ,0,0,0,32'h3004,0,0));
        vecs.push_back(v(1,0,0,NPC_JAL,0,26'hC40,0,32'h3100,1,0));
        vecs.push_back(v(1,0,0,NPC_RET,0,0,32'h3008,32'h3008,0,1));
        vecs.push_back(v(1,0,0,NPC_SEQ,0,0,0,32'h300C,0,0));
        vecs.push_back(v(1,0,0,NPC_RET,0,0,32'h5000,32'h5000,0,0));
        // negative branch wrap
        vecs.push_back(v(1,0,0,NPC_JR,0,0,32'h10,32'h10,0,0));
        vecs.push_back(v(1,0,0,NPC_BEQ,1,26'h8000,0,32'hFFFE_0014,0,0));
        vecs.push_back(v(1,0,0,NPC_BEQ,0,26'h8000,0,32'hFFFE_0018,0,0));
        vecs.push_back(v(1,0,0,NPC_BNE,0,26'h0001,0,32'hFFFE_0020,0,0));
        // overflow: push A..E
        vecs.push_back(v(1,0,0,NPC_JR,0,0,32'h100,32'h100,0,0));
        vecs.push_back(v(1,0,0,NPC_JAL,0,26'h400,0,32'h1000,1,0));
        vecs.push_back(v(1,0,0,NPC_JAL,0,26'h500,0,32'h1400,2,0));
        vecs.push_back(v(1,0,0,NPC_JAL,0,26'h600,0,32'h1800,3,0));
        vecs.push_back(v(1,0,0,NPC_JAL,0,26'h700,0,32'h1C00,4,0));
        vecs.push_back(v(1,0,0,NPC_JAL,0,26'h800,0,32'h2000,4,0));
        // stall with JAL pending
        vecs.push_back(v(1,1,0,NPC_JAL,0,26'h900,0,32'h2000,4,0));
        vecs.push_back(v(1,1,0,NPC_JAL,0,26'h900,0,32'h2000,4,0));
        vecs.push_back(v(1,1,0,NPC_JAL,0,26'h900,0,32'h2000,4,0));
        // redirect during RET leaves RAS intact
        vecs.push_back(v(1,0,1,NPC_RET,0,0,32'h1C04,32'h4180,4,0));
        vecs.push_back(v(1,0,0,NPC_RET,0,0,32'h1C04,32'h1C04,3,1));
        vecs.push_back(v(1,0,0,NPC_RET,0,0,32'h1804,32'h1804,2,1));
        vecs.push_back(v(1,0,0,NPC_RET,0,0,32'h1404,32'h1404,1,1));
        vecs.push_back(v(1,0,0,NPC_RET,0,0,32'h1004,32'h1004,0,1));
        vecs.push_back(v(1,0,0,NPC_RET,0,0,32'h104,32'h104,0,0));
        // stall + redirect, reserved mode
        vecs.push_back(v(1,1,1,NPC_SEQ,0,0,0,32'h4180,0,0));
        vecs.push_back(v(1,0,0,NPC_RSV,0,0,0,32'h4184,0,0));
        // reset discards RAS
        vecs.push_back(v(1,0,0,NPC_JAL,0,26'h400,0,32'h1000,1,0));
        vecs.push_back(v(0,0,0,NPC_RET,0,0,32'h1004,32'h3000,0,0));
        vecs.push_back(v(1,0,0,NPC_RET,0,0,32'h3004,32'h3004,0,0));
        // mismatching RET still pops; byte bits of reg_val cleared
        vecs.push_back(v(1,0,0,NPC_JAL,0,26'h400,0,32'h1000,1,0));
        vecs.push_back(v(1,0,0,NPC_RET,0,0,32'h2222,32'h2220,0,0));
        vecs.push_back(v(1,0,0,NPC_SEQ,0,0,0,32'h2224,0,0));

        rst28 = 1'b0; stall28 = 1'b0; redirect28 = 1'b0; zero28 = 1'b0;
        sel28 = NPC_SEQ; imm28 = '0; reg28 = '0;

        for (int i = 0; i < vecs.size(); i++) begin
            rst      = vecs[i].rst;
            stall    = vecs[i].stall;
            redirect = vecs[i].redirect;
            npc_sel  = vecs[i].sel;
            zero     = vecs[i].zero;
            imm      = vecs[i].imm;
            reg_val  = vecs[i].reg_val;
            if (i > 0) begin
                #1;
                chk("pc_plus4_pre", i, pc_plus4, vecs[i-1].exp_pc + 32'd4);
            end
            @(posedge clk);
            #1;
            chk("pc", i, pc, vecs[i].exp_pc);
            chk("pc_plus4", i, pc_plus4, vecs[i].exp_pc + 32'd4);
            chk("ras_count", i, {29'd0, ras_count}, vecs[i].exp_cnt);
            chk("ras_hit", i, {31'd0, ras_hit}, {31'd0, vecs[i].exp_hit});
        end

        // ADDR_W=28 instance: jump to the top, then wrap
        @(posedge clk); #1;
        chk("pc28_reset", 0, {4'd0, pc28}, 32'h3000);
        chk("cnt28_reset", 0, {29'd0, cnt28}, 0);
        rst28 = 1'b1; sel28 = NPC_J; imm28 = 26'h3FF_FFFF;
        @(posedge clk); #1;
        chk("pc28_j", 1, {4'd0, pc28}, 32'h0FFF_FFFC);
        chk("pp4_28_wrap", 1, {4'd0, pp4_28}, 32'h0);
        sel28 = NPC_SEQ;
        @(posedge clk); #1;
        chk("pc28_seq", 2, {4'd0, pc28}, 32'h0);
        sel28 = NPC_BNE; zero28 = 1'b0; imm28 = 26'hFFFE;
        @(posedge clk); #1;
        chk("pc28_bneg", 3, {4'd0, pc28}, 32'h0FFF_FFFC);
        sel28 = NPC_JAL; imm28 = 26'h10;
        @(posedge clk); #1;
        chk("pc28_jal", 4, {4'd0, pc28}, 32'h40);
        chk("cnt28_jal", 4, {29'd0, cnt28}, 1);
        sel28 = NPC_RET; reg28 = 32'h0;
        @(posedge clk); #1;
        chk("hit28_ret", 5, {31'd0, hit28}, 1);
        chk("pc28_ret", 5, {4'd0, pc28}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
